// File: rtl/rv_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rv_run_ctrl
// Purpose  : Run-control sequencer (halt/resume/step/breakpoint) and
//            retired-instruction / active-cycle counters for the pipeline.
// Revision : 1.0
// ============================================================================
module rv_run_ctrl #(
  parameter int XLEN         = 32,
  parameter int CNT_W        = 32,
  parameter int STEP_TIMEOUT = 16,
  parameter int START_HALTED = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [2:0]       i_cmd_op,
  input  logic [XLEN-1:0]  i_cmd_data,
  input  logic             i_commit_valid,
  input  logic [XLEN-1:0]  i_commit_pc,
  output logic             o_core_en,
  output logic             o_halted,
  output logic [1:0]       o_halt_cause,
  output logic             o_bp_active,
  output logic [CNT_W-1:0] o_instret,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  localparam logic [1:0] c_ST_RUN    = 2'd0;
  localparam logic [1:0] c_ST_HALTED = 2'd1;
  localparam logic [1:0] c_ST_STEP   = 2'd2;
  localparam logic [1:0] c_ST_RESET  = (START_HALTED != 0) ? c_ST_HALTED : c_ST_RUN;

  localparam logic [2:0] c_OP_HALT   = 3'b000;
  localparam logic [2:0] c_OP_RESUME = 3'b001;
  localparam logic [2:0] c_OP_STEP   = 3'b010;
  localparam logic [2:0] c_OP_SET_BP = 3'b011;
  localparam logic [2:0] c_OP_CLR_BP = 3'b100;
  localparam logic [2:0] c_OP_CLR_CNT = 3'b101;

  localparam logic [1:0] c_CAUSE_CMD     = 2'b00;
  localparam logic [1:0] c_CAUSE_BP      = 2'b01;
  localparam logic [1:0] c_CAUSE_STEP    = 2'b10;
  localparam logic [1:0] c_CAUSE_TIMEOUT = 2'b11;

  localparam int               c_TMR_W    = (STEP_TIMEOUT > 1) ? $clog2(STEP_TIMEOUT) : 1;
  localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(STEP_TIMEOUT - 1);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [1:0]         r_cause;
  logic [1:0]         w_cause_nxt;
  logic               r_bp_active;
  logic [XLEN-1:0]    r_bp_addr;
  logic [CNT_W-1:0]   r_instret;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [c_TMR_W-1:0] r_step_tmr;

  logic w_core_en;
  logic w_halted;
  logic w_cmd_ready;
  logic w_cmd_acc;
  logic w_qc;
  logic w_bp_hit;
  logic w_tmr_last;

  assign w_cmd_acc  = i_cmd_valid & w_cmd_ready;
  assign w_qc       = i_commit_valid & w_core_en;
  // Compared against the address held before any same-cycle SET_BP lands.
  assign w_bp_hit   = w_qc & r_bp_active & (i_commit_pc == r_bp_addr);
  assign w_tmr_last = (r_step_tmr == c_TMR_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= c_ST_RESET;
      r_cause <= c_CAUSE_CMD;
    end else begin
      r_state <= w_state_nxt;
      r_cause <= w_cause_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    w_cause_nxt = r_cause;
    case (r_state)
      c_ST_RUN: begin
        if (w_bp_hit) begin
          w_state_nxt = c_ST_HALTED;
          w_cause_nxt = c_CAUSE_BP;
        end else if (w_cmd_acc && (i_cmd_op == c_OP_HALT)) begin
          w_state_nxt = c_ST_HALTED;
          w_cause_nxt = c_CAUSE_CMD;
        end
      end
      c_ST_HALTED: begin
        if (w_cmd_acc && (i_cmd_op == c_OP_RESUME)) begin
          w_state_nxt = c_ST_RUN;
        end else if (w_cmd_acc && (i_cmd_op == c_OP_STEP)) begin
          w_state_nxt = c_ST_STEP;
        end
      end
      c_ST_STEP: begin
        if (w_qc) begin
          w_state_nxt = c_ST_HALTED;
          w_cause_nxt = w_bp_hit ? c_CAUSE_BP : c_CAUSE_STEP;
        end else if (w_tmr_last) begin
          w_state_nxt = c_ST_HALTED;
          w_cause_nxt = c_CAUSE_TIMEOUT;
        end
      end
      default: begin
        w_state_nxt = c_ST_HALTED;
      end
    endcase
  end

  // Output decode from registered state
  always_comb begin
    w_core_en   = 1'b1;
    w_halted    = 1'b0;
    w_cmd_ready = 1'b1;
    case (r_state)
      c_ST_HALTED: begin
        w_core_en = 1'b0;
        w_halted  = 1'b1;
      end
      c_ST_STEP: begin
        w_cmd_ready = 1'b0;
      end
      default: begin
        w_core_en = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step_tmr <= '0;
    end else if ((r_state == c_ST_HALTED) && (w_state_nxt == c_ST_STEP)) begin
      r_step_tmr <= '0;
    end else if ((r_state == c_ST_STEP) && w_core_en) begin
      r_step_tmr <= r_step_tmr + c_TMR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_bp_active <= 1'b0;
      r_bp_addr   <= '0;
    end else if (w_cmd_acc && (i_cmd_op == c_OP_SET_BP)) begin
      r_bp_active <= 1'b1;
      r_bp_addr   <= i_cmd_data;
    end else if (w_cmd_acc && (i_cmd_op == c_OP_CLR_BP)) begin
      r_bp_active <= 1'b0;
    end
  end

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk) begin
    if (reset || (w_cmd_acc && (i_cmd_op == c_OP_CLR_CNT))) begin
      r_instret   <= '0;
      r_cycle_cnt <= '0;
    end else begin
      r_instret   <= r_instret + CNT_W'(w_qc);
      r_cycle_cnt <= r_cycle_cnt + CNT_W'(w_core_en);
    end
  end

  assign o_cmd_ready  = w_cmd_ready;
  assign o_core_en    = w_core_en;
  assign o_halted     = w_halted;
  assign o_halt_cause = r_cause;
  assign o_bp_active  = r_bp_active;
  assign o_instret    = r_instret;
  assign o_cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire

// File: tb/tb_rv_run_ctrl.sv
`default_nettype none
// Table-driven bench for rv_run_ctrl with default parameters
// (START_HALTED=0, STEP_TIMEOUT=16), plus hand-written step corner cases.
module tb_rv_run_ctrl;

  localparam logic [2:0] c_OP_HALT    = 3'd0;
  localparam logic [2:0] c_OP_RESUME  = 3'd1;
  localparam logic [2:0] c_OP_STEP    = 3'd2;
  localparam logic [2:0] c_OP_SET_BP  = 3'd3;
  localparam logic [2:0] c_OP_CLR_BP  = 3'd4;
  localparam logic [2:0] c_OP_CLR_CNT = 3'd5;
  localparam logic [2:0] c_OP_RSVD    = 3'd6;

  localparam int c_R = 0;
  localparam int c_H = 1;
  localparam int c_S = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [31:0] cmd_data;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic        core_en;
  logic        halted;
  logic [1:0]  halt_cause;
  logic        bp_active;
  logic [31:0] instret;
  logic [31:0] cycle_cnt;

  int n_tot = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst;
    logic        cv;
    logic [2:0]  op;
    logic [31:0] data;
    logic        mv;
    logic [31:0] pc;
    logic        en;
    logic        hlt;
    logic        rdy;
    logic [1:0]  cause;
    logic        bp;
    logic [31:0] ins;
    logic [31:0] cyc;
  } vec_t;

  vec_t tbl[$];

  rv_run_ctrl #(
    .XLEN(32), .CNT_W(32), .STEP_TIMEOUT(16), .START_HALTED(0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_cmd_valid   (cmd_valid),
    .o_cmd_ready   (cmd_ready),
    .i_cmd_op      (cmd_op),
    .i_cmd_data    (cmd_data),
    .i_commit_valid(commit_valid),
    .i_commit_pc   (commit_pc),
    .o_core_en     (core_en),
    .o_halted      (halted),
    .o_halt_cause  (halt_cause),
    .o_bp_active   (bp_active),
    .o_instret     (instret),
    .o_cycle_cnt   (cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", nm, got, exp);
    end
  endtask

  // st: expected state after the edge; core_en/halted/cmd_ready follow from it.
  task automatic add(input logic rst, input logic cv, input logic [2:0] op,
                     input logic [31:0] data, input logic mv, input logic [31:0] pc,
                     input int st, input logic [1:0] cause, input logic bp,
                     input logic [31:0] ins, input logic [31:0] cyc);
    vec_t v;
    v.rst = rst; v.cv = cv; v.op = op; v.data = data; v.mv = mv; v.pc = pc;
    v.en  = (st != c_H);
    v.hlt = (st == c_H);
    v.rdy = (st != c_S);
    v.cause = cause; v.bp = bp; v.ins = ins; v.cyc = cyc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic cv, input logic [2:0] op,
                       input logic [31:0] data, input logic mv, input logic [31:0] pc);
    reset = rst; cmd_valid = cv; cmd_op = op; cmd_data = data;
    commit_valid = mv; commit_pc = pc;
  endtask

  initial begin
    int n_en;
    drive(1'b1, 1'b0, 3'd0, 32'h0, 1'b0, 32'h0);

    // Reset, then ten straight-line commits
    add(1, 0, 0, 0, 0, 0, c_R, 2'd0, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 0, 0, 0, 1, 32'h100 + 32'(4 * i), c_R, 2'd0, 0, 32'(i + 1), 32'(i + 1));
    add(0, 0, 0, 0, 0, 0, c_R, 2'd0, 0, 10, 11);
    // Breakpoint at 0x10, held 0x14 in WB until RESUME
    add(0, 1, c_OP_SET_BP, 32'h10, 0, 0, c_R, 2'd0, 1, 10, 12);
    add(0, 0, 0, 0, 1, 32'h08, c_R, 2'd0, 1, 11, 13);
    add(0, 0, 0, 0, 1, 32'h0C, c_R, 2'd0, 1, 12, 14);
    add(0, 0, 0, 0, 1, 32'h10, c_H, 2'd1, 1, 13, 15);
    add(0, 0, 0, 0, 1, 32'h14, c_H, 2'd1, 1, 13, 15);
    add(0, 1, c_OP_RESUME, 0, 1, 32'h14, c_R, 2'd1, 1, 13, 15);
    add(0, 0, 0, 0, 1, 32'h14, c_R, 2'd1, 1, 14, 16);
    // HALT, HALT no-op, three single steps (HALT ignored while stepping)
    add(0, 1, c_OP_HALT, 0, 0, 0, c_H, 2'd0, 1, 14, 17);
    add(0, 1, c_OP_HALT, 0, 0, 0, c_H, 2'd0, 1, 14, 17);
    add(0, 1, c_OP_STEP, 0, 0, 0, c_S, 2'd0, 1, 14, 17);
    add(0, 1, c_OP_HALT, 0, 0, 0, c_S, 2'd0, 1, 14, 18);
    add(0, 0, 0, 0, 1, 32'h18, c_H, 2'd2, 1, 15, 19);
    add(0, 1, c_OP_STEP, 0, 0, 0, c_S, 2'd2, 1, 15, 19);
    add(0, 0, 0, 0, 1, 32'h1C, c_H, 2'd2, 1, 16, 20);
    add(0, 1, c_OP_STEP, 0, 0, 0, c_S, 2'd2, 1, 16, 20);
    add(0, 0, 0, 0, 1, 32'h20, c_H, 2'd2, 1, 17, 21);
    // Step over bubbles only: forced halt after 16 enabled cycles
    add(0, 1, c_OP_STEP, 0, 0, 0, c_S, 2'd2, 1, 17, 21);
    for (int j = 1; j < 16; j++)
      add(0, 0, 0, 0, 0, 0, c_S, 2'd2, 1, 17, 32'(21 + j));
    add(0, 0, 0, 0, 0, 0, c_H, 2'd3, 1, 17, 37);
    add(0, 0, 0, 0, 0, 0, c_H, 2'd3, 1, 17, 37);
    // HALT together with bp hit, CLR_BP, CLR_CNT with a commit, RUN no-ops
    add(0, 1, c_OP_RESUME, 0, 0, 0, c_R, 2'd3, 1, 17, 37);
    add(0, 1, c_OP_HALT, 0, 1, 32'h10, c_H, 2'd1, 1, 18, 38);
    add(0, 1, c_OP_RESUME, 0, 0, 0, c_R, 2'd1, 1, 18, 38);
    add(0, 1, c_OP_CLR_BP, 0, 1, 32'h24, c_R, 2'd1, 0, 19, 39);
    add(0, 0, 0, 0, 1, 32'h10, c_R, 2'd1, 0, 20, 40);
    add(0, 1, c_OP_CLR_CNT, 0, 1, 32'h28, c_R, 2'd1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 32'h2C, c_R, 2'd1, 0, 1, 1);
    add(0, 1, c_OP_RSVD, 0, 1, 32'h30, c_R, 2'd1, 0, 2, 2);
    add(0, 1, c_OP_STEP, 0, 1, 32'h34, c_R, 2'd1, 0, 3, 3);
    add(0, 1, c_OP_RESUME, 0, 1, 32'h38, c_R, 2'd1, 0, 4, 4);
    // Reset in the middle of a step
    add(0, 1, c_OP_SET_BP, 32'h40, 0, 0, c_R, 2'd1, 1, 4, 5);
    add(0, 1, c_OP_HALT, 0, 0, 0, c_H, 2'd0, 1, 4, 6);
    add(0, 1, c_OP_STEP, 0, 0, 0, c_S, 2'd0, 1, 4, 6);
    add(0, 0, 0, 0, 0, 0, c_S, 2'd0, 1, 4, 7);
    add(1, 1, c_OP_HALT, 0, 1, 32'h40, c_R, 2'd0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, c_R, 2'd0, 0, 0, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].cv, tbl[i].op, tbl[i].data, tbl[i].mv, tbl[i].pc);
      tick();
      chk($sformatf("v%0d.core_en", i),    64'(core_en),    64'(tbl[i].en));
      chk($sformatf("v%0d.halted", i),     64'(halted),     64'(tbl[i].hlt));
      chk($sformatf("v%0d.cmd_ready", i),  64'(cmd_ready),  64'(tbl[i].rdy));
      chk($sformatf("v%0d.halt_cause", i), 64'(halt_cause), 64'(tbl[i].cause));
      chk($sformatf("v%0d.bp_active", i),  64'(bp_active),  64'(tbl[i].bp));
      chk($sformatf("v%0d.instret", i),    64'(instret),    64'(tbl[i].ins));
      chk($sformatf("v%0d.cycle_cnt", i),  64'(cycle_cnt),  64'(tbl[i].cyc));
    end

    // Step whose single commit lands on the breakpoint -> cause 01
    drive(0, 1, c_OP_SET_BP, 32'h50, 0, 0); tick();
    drive(0, 1, c_OP_HALT, 0, 0, 0);        tick();
    drive(0, 1, c_OP_STEP, 0, 0, 0);        tick();
    chk("stepbp.ready_in_step", 64'(cmd_ready), 64'd0);
    drive(0, 0, 0, 0, 1, 32'h50);           tick();
    chk("stepbp.halted",  64'(halted),     64'd1);
    chk("stepbp.cause",   64'(halt_cause), 64'd1);
    chk("stepbp.instret", 64'(instret),    64'd1);

    // Timeout step measured with a bounded wait
    drive(0, 1, c_OP_STEP, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n_en = 0;
    for (int k = 0; k < 40 && !halted; k++) begin
      if (core_en) n_en++;
      tick();
    end
    chk("tmo.halted",     64'(halted),     64'd1);
    chk("tmo.en_cycles",  64'(n_en),       64'd16);
    chk("tmo.cause",      64'(halt_cause), 64'd3);
    chk("tmo.instret",    64'(instret),    64'd1);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
